// File: rtl/plugboard_stage.sv
// plugboard_stage: programmable letter-swap table applied to one ASCII character every 3 cycles.
// dout is loaded leaving LOOK; done is registered, so it pulses the cycle after DONE.
module plugboard_stage #(
    parameter int MAX_PAIRS = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       pair_we,
    input  logic [7:0] pair_a,
    input  logic [7:0] pair_b,
    input  logic       valid,
    input  logic [7:0] din,
    output logic       ready,
    output logic [7:0] dout,
    output logic       done,
    output logic [3:0] pair_cnt,
    output logic       cfg_err
);
    typedef enum logic [1:0] {IDLE, LOOK, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] tbl [26];
    logic [7:0] chr;
    logic [7:0] a_off, b_off, c_off;
    logic       a_ok, b_ok, c_ok, wr_ok;
    // Offsets wrap for codes below 'A', so one unsigned compare checks the whole range
    assign a_off = pair_a - 8'd65;
    assign b_off = pair_b - 8'd65;
    assign c_off = chr - 8'd65;
    assign a_ok  = a_off < 8'd26;
    assign b_ok  = b_off < 8'd26;
    assign c_ok  = c_off < 8'd26;
    assign wr_ok = a_ok && b_ok && pair_a != pair_b
                && tbl[a_off[4:0]] == a_off[4:0] && tbl[b_off[4:0]] == b_off[4:0]
                && pair_cnt < 4'(MAX_PAIRS);
    assign ready = state == IDLE;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (valid ? LOOK : IDLE) : state == LOOK ? DONE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            chr      <= 8'h00;
            dout     <= 8'h00;
            done     <= 1'b0;
            pair_cnt <= 4'd0;
            cfg_err  <= 1'b0;
            for (int i = 0; i < 26; i++) tbl[i] <= 5'(i);
        end else begin
            state <= state_nx;
            done  <= state == DONE;
            if (state == LOOK) dout <= c_ok ? 8'd65 + {3'b000, tbl[c_off[4:0]]} : chr;
            if (state != IDLE) begin
                if (pair_we) cfg_err <= 1'b1;
            end else if (valid) begin
                chr <= din;
                if (pair_we) cfg_err <= 1'b1;
            end else if (clr) begin
                pair_cnt <= 4'd0;
                cfg_err  <= 1'b0;
                for (int i = 0; i < 26; i++) tbl[i] <= 5'(i);
            end else if (pair_we) begin
                if (wr_ok) begin
                    tbl[a_off[4:0]] <= b_off[4:0];
                    tbl[b_off[4:0]] <= a_off[4:0];
                    pair_cnt        <= pair_cnt + 4'd1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_plugboard_stage.sv
// tb_plugboard_stage: directed scenarios plus random traffic, checked every cycle
// against a letter-map model with countdown timers for the result and done pulse.
module tb_plugboard_stage;
    logic       clk = 1'b0;
    logic       reset, clr, pair_we, valid;
    logic [7:0] pair_a, pair_b, din;
    logic       ready, done, cfg_err;
    logic [7:0] dout;
    logic [3:0] pair_cnt;

    int n_chk = 0;
    int n_pass = 0;
    bit started = 0;

    int map [26];
    int m_cnt, m_err, m_busy, m_dout_in, m_done_in, m_dout, m_done, m_res;

    plugboard_stage dut (
        .clk(clk), .reset(reset), .clr(clr), .pair_we(pair_we),
        .pair_a(pair_a), .pair_b(pair_b), .valid(valid), .din(din),
        .ready(ready), .dout(dout), .done(done), .pair_cnt(pair_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_letter(int c);
        return c >= 65 && c <= 90;
    endfunction

    function automatic int subst(int c);
        return is_letter(c) ? map[c-65] : c;
    endfunction

    function automatic bit can_pair(int a, int b);
        return is_letter(a) && is_letter(b) && a != b && map[a-65] == a && map[b-65] == b && m_cnt < 13;
    endfunction

    // Reference model: reacts to the inputs sampled on each rising edge
    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            for (int i = 0; i < 26; i++) map[i] = 65 + i;
            m_cnt = 0; m_err = 0; m_busy = 0; m_dout_in = 0; m_done_in = 0;
            m_dout = 0; m_done = 0; m_res = 0;
        end else begin
            m_done = 0;
            if (m_dout_in > 0) begin
                m_dout_in -= 1;
                if (m_dout_in == 0) m_dout = m_res;
            end
            if (m_done_in > 0) begin
                m_done_in -= 1;
                if (m_done_in == 0) m_done = 1;
            end
            if (m_busy > 0) begin
                m_busy -= 1;
                if (pair_we) m_err = 1;
            end else if (valid) begin
                m_res = subst(int'(din));
                m_dout_in = 1; m_done_in = 2; m_busy = 2;
                if (pair_we) m_err = 1;
            end else if (clr) begin
                for (int i = 0; i < 26; i++) map[i] = 65 + i;
                m_cnt = 0; m_err = 0;
            end else if (pair_we) begin
                if (can_pair(int'(pair_a), int'(pair_b))) begin
                    map[int'(pair_a)-65] = int'(pair_b);
                    map[int'(pair_b)-65] = int'(pair_a);
                    m_cnt += 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", ready, m_busy == 0);
            chk("done", done, m_done);
            chk("dout", dout, m_dout);
            chk("pair_cnt", pair_cnt, m_cnt);
            chk("cfg_err", cfg_err, m_err);
        end
    end

    task automatic quiet();
        valid = 0; pair_we = 0; clr = 0;
    endtask

    task automatic install(input logic [7:0] a, input logic [7:0] b);
        pair_we = 1; pair_a = a; pair_b = b;
        @(negedge clk);
        pair_we = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        @(negedge clk);
        clr = 0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] e);
        int k;
        valid = 1; din = c;
        @(negedge clk);
        valid = 0;
        k = 0;
        while (!done && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("send_done", done, 1);
        chk("send_dout", dout, e);
    endtask

    function automatic logic [7:0] rand_char();
        return $urandom_range(0, 9) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(65, 90));
    endfunction

    initial begin
        int nd;
        reset = 1; clr = 0; pair_we = 0; valid = 0; pair_a = 0; pair_b = 0; din = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cnt", pair_cnt, 0);
        chk("rst_err", cfg_err, 0);
        send(8'd81, 8'd81);

        install("A", "Z");
        chk("swap_cnt", pair_cnt, 1);
        send("A", 8'd90);
        send("Z", 8'd65);
        send("B", 8'd66);

        install("A", "C");
        chk("rej_paired_err", cfg_err, 1);
        install("D", "D");
        install("a", "E");
        chk("rej_cnt", pair_cnt, 1);
        chk("rej_err", cfg_err, 1);
        send("A", 8'd90);
        send("C", 8'd67);
        do_clr();
        chk("clr_err", cfg_err, 0);
        chk("clr_cnt", pair_cnt, 0);
        send("A", 8'd65);

        for (int i = 0; i < 13; i++) install(8'(65 + 2*i), 8'(66 + 2*i));
        chk("full_cnt", pair_cnt, 13);
        chk("full_err0", cfg_err, 0);
        install("A", "C");
        chk("full_err", cfg_err, 1);
        chk("full_cnt2", pair_cnt, 13);
        send("M", 8'd78);
        send("Y", 8'd90);
        send("5", 8'd53);

        do_clr();
        valid = 1; din = "C";
        @(negedge clk);
        valid = 0; pair_we = 1; pair_a = "C"; pair_b = "D";
        @(negedge clk);
        pair_we = 0;
        chk("look_we_err", cfg_err, 1);
        chk("look_we_cnt", pair_cnt, 0);
        valid = 1; din = "E";
        @(negedge clk);
        valid = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) nd++;
            if (i == 0) chk("busy_dout", dout, 67);
            @(negedge clk);
        end
        chk("one_done", nd, 1);
        do_clr();
        valid = 1; din = "F"; pair_we = 1; pair_a = "F"; pair_b = "G";
        @(negedge clk);
        quiet();
        chk("vw_err", cfg_err, 1);
        repeat (2) @(negedge clk);
        chk("vw_done", done, 1);
        chk("vw_dout", dout, 70);
        chk("vw_cnt", pair_cnt, 0);

        install("H", "I");
        valid = 1; din = "H";
        @(negedge clk);
        valid = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort_ready", ready, 1);
        chk("abort_dout", dout, 0);
        chk("abort_cnt", pair_cnt, 0);
        chk("abort_err", cfg_err, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", nd, 0);

        for (int i = 0; i < 600; i++) begin
            reset   = $urandom_range(0, 99) < 2;
            valid   = $urandom_range(0, 99) < 30;
            din     = rand_char();
            pair_we = $urandom_range(0, 99) < 40;
            pair_a  = rand_char();
            pair_b  = rand_char();
            clr     = $urandom_range(0, 99) < 4;
            @(negedge clk);
        end
        reset = 0;
        quiet();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
